// File: rtl/seg_wishbone_scan.sv
// seg_wishbone_scan: Wishbone-slave multiplexed seven-segment driver with per-slot PWM dimming
module seg_wishbone_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [1:0]            ADR_I,
  input  logic [31:0]           DAT_I,
  output logic [31:0]           DAT_O,
  output logic                  ACK_O,
  output logic [6:0]            O_cathode,
  output logic                  O_dp,
  output logic [NUM_DIGITS-1:0] O_anode
);
  localparam int TICKS    = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PRESCALE = TICKS / 16;
  localparam int PW       = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int DW       = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dpmask, enable;
  logic [3:0]              bright, phase, nib;
  logic [PW-1:0]           pre;
  logic [DW-1:0]           digit;
  logic                    take, pre_wrap, on;
  logic [31:0]             rdata;
  logic [6:0]              glyph;
  assign take     = CYC_I & STB_I & ~ACK_O;
  assign pre_wrap = pre == PW'(PRESCALE - 1);
  assign on       = enable[digit] && phase <= bright;
  assign nib      = data[{digit, 2'b00} +: 4];
  assign rdata    = ADR_I == 2'd0 ? 32'(data) :
                    ADR_I == 2'd1 ? 32'(dpmask) :
                    ADR_I == 2'd2 ? 32'(enable) : 32'(bright);
  always_comb begin
    glyph = 7'b1111111;
    case (nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
      default: glyph = 7'b1111111;
    endcase
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      data      <= '0;
      dpmask    <= '0;
      enable    <= '1;
      bright    <= 4'hF;
      ACK_O     <= 1'b0;
      DAT_O     <= '0;
      pre       <= '0;
      phase     <= '0;
      digit     <= '0;
      O_anode   <= '1;
      O_cathode <= '1;
      O_dp      <= 1'b1;
    end else begin
      ACK_O <= take;
      DAT_O <= (take && !WE_I) ? rdata : '0;
      if (take && WE_I) begin
        case (ADR_I)
          2'd0: data <= DAT_I[4*NUM_DIGITS-1:0];
          2'd1: dpmask <= DAT_I[NUM_DIGITS-1:0];
          2'd2: enable <= DAT_I[NUM_DIGITS-1:0];
          default: bright <= DAT_I[3:0];
        endcase
      end
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) begin
        phase <= phase + 1'b1;
        if (phase == 4'hF) digit <= digit == DW'(NUM_DIGITS - 1) ? '0 : digit + 1'b1;
      end
      // outputs latch this cycle's scan/register state so pins change on a clean edge
      O_anode   <= on ? ~(NUM_DIGITS'(1) << digit) : '1;
      O_cathode <= on ? glyph : '1;
      O_dp      <= on ? ~dpmask[digit] : 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_wishbone_scan.sv
// tb_seg_wishbone_scan: directed + random bus traffic against a cycle-count based display model
module tb_seg_wishbone_scan;
  logic        clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [1:0]  adr = 0;
  logic [31:0] dat = 0;
  logic [31:0] dat_o;
  logic        ack_o, dp_o;
  logic [6:0]  cath_o;
  logic [3:0]  an_o;
  int n_cmp = 0, n_err = 0;

  seg_wishbone_scan #(.NUM_DIGITS(4), .CLK_HZ(1600), .REFRESH_HZ(25)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
    .DAT_O(dat_o), .ACK_O(ack_o), .O_cathode(cath_o), .O_dp(dp_o), .O_anode(an_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] G [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // reference: display position is a pure function of cycles since reset release
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_en, m_br, exp_an;
  logic        m_ack, exp_dp;
  logic [6:0]  exp_cat;
  logic [31:0] exp_dat;
  int          t;

  function automatic logic [31:0] mread(input logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_data};
      2'd1: return {28'h0, m_dp};
      2'd2: return {28'h0, m_en};
      default: return {28'h0, m_br};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= 0; m_dp <= 0; m_en <= 4'hF; m_br <= 4'hF; m_ack <= 0; t <= 0;
      exp_an <= 4'hF; exp_cat <= 7'h7F; exp_dp <= 1; exp_dat <= 0;
    end else begin
      automatic int d = (t / 16) % 4;
      automatic int ph = t % 16;
      automatic bit lit = m_en[d] && ph <= int'(m_br);
      automatic bit tk = cyc && stb && !m_ack;
      exp_an  <= lit ? ~(4'(1) << d) : 4'hF;
      exp_cat <= lit ? G[(m_data >> (4 * d)) & 16'hF] : 7'h7F;
      exp_dp  <= lit ? ~m_dp[d] : 1'b1;
      t       <= t + 1;
      m_ack   <= tk;
      exp_dat <= (tk && !we) ? mread(adr) : 0;
      if (tk && we) begin
        if (adr == 0) m_data <= dat[15:0];
        if (adr == 1) m_dp <= dat[3:0];
        if (adr == 2) m_en <= dat[3:0];
        if (adr == 3) m_br <= dat[3:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("anode", 32'(an_o), 32'(exp_an));
    chk("cathode", 32'(cath_o), 32'(exp_cat));
    chk("dp", 32'(dp_o), 32'(exp_dp));
    chk("ack", 32'(ack_o), 32'(m_ack));
    chk("dat_o", dat_o, exp_dat);
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
    int n = 0;
    cyc = 1; stb = 1; we = w; adr = a; dat = d;
    do begin step(); n++; end while (!ack_o && n < 4);
    chk("ack_timeout", 32'(ack_o), 32'd1);
    q = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  initial begin
    logic [31:0] q, e;
    int cnt [4];
    int bad, acks;
    logic [6:0] c2 [4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (37) step();
    // reset mid-scan: outputs must blank without waiting for a clock edge
    #2 rst = 1;
    #1;
    chk("rst_anode", 32'(an_o), 32'hF);
    chk("rst_cathode", 32'(cath_o), 32'h7F);
    chk("rst_dp", 32'(dp_o), 32'd1);
    chk("rst_ack", 32'(ack_o), 32'd0);
    @(negedge clk);
    rst = 0;
    step();
    chk("first_anode", 32'(an_o), 32'hE);
    bus(0, 0, 0, q); chk("rst_data", q, 32'h0);
    bus(0, 1, 0, q); chk("rst_dpmask", q, 32'h0);
    bus(0, 2, 0, q); chk("rst_enable", q, 32'hF);
    bus(0, 3, 0, q); chk("rst_bright", q, 32'hF);
    // glyph scan at full brightness
    bus(1, 0, 32'h0000_3210, q);
    bus(1, 3, 32'hF, q);
    step();
    cnt = '{0, 0, 0, 0}; bad = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (an_o == ~(4'(1) << i)) begin cnt[i]++; if (cath_o != c2[i]) bad++; end
    end
    for (int i = 0; i < 4; i++) chk("slot_len", 32'(cnt[i]), 32'd16);
    chk("glyph_bad", 32'(bad), 32'd0);
    // dimming: 4 of 16 cycles lit, blank otherwise
    bus(1, 3, 32'h3, q);
    step();
    cnt = '{0, 0, 0, 0}; bad = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (!an_o[i]) cnt[i]++;
      if (an_o == 4'hF && (cath_o != 7'h7F || dp_o != 1)) bad++;
    end
    for (int i = 0; i < 4; i++) chk("dim_on", 32'(cnt[i]), 32'd4);
    chk("dim_blank", 32'(bad), 32'd0);
    // enable / dp masks
    bus(1, 2, 32'h5, q);
    bus(1, 1, 32'h1, q);
    step();
    cnt = '{0, 0, 0, 0}; bad = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (!an_o[i]) cnt[i]++;
      if ((dp_o == 0) != (an_o == 4'hE)) bad++;
    end
    chk("dis1", 32'(cnt[1]), 32'd0);
    chk("dis3", 32'(cnt[3]), 32'd0);
    chk("en0", 32'(cnt[0]), 32'd4);
    chk("en2", 32'(cnt[2]), 32'd4);
    chk("dp_only_d0", 32'(bad), 32'd0);
    // unused data bits dropped; ack is a single pulse; held strobe gives one ack per 2 cycles
    bus(1, 0, 32'hFFFF_ABCD, q);
    bus(0, 0, 0, q);
    chk("rd_abcd", q, 32'h0000_ABCD);
    step();
    chk("ack_pulse", 32'(ack_o), 32'd0);
    chk("dat_idle", dat_o, 32'd0);
    cyc = 1; stb = 1; we = 0; adr = 0; acks = 0;
    for (int k = 0; k < 10; k++) begin step(); if (ack_o) acks++; end
    cyc = 0; stb = 0;
    chk("held_acks", 32'(acks), 32'd5);
    step();
    // strobe without cycle is ignored
    cyc = 0; stb = 1; we = 1; adr = 0; dat = 32'h1234_5678; acks = 0;
    for (int k = 0; k < 6; k++) begin step(); if (ack_o) acks++; end
    stb = 0; we = 0;
    chk("nocyc_acks", 32'(acks), 32'd0);
    bus(0, 0, 0, q);
    chk("nocyc_data", q, 32'h0000_ABCD);
    // random traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic w;
      logic [1:0] a;
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      e = mread(a);
      bus(w, a, $urandom, q);
      if (!w) chk("rand_rd", q, e);
      repeat ($urandom_range(0, 20)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
